spram_read_arbiter: RTL and testbench

- Shares one single-port 16-bit SPRAM (registered output, 1-cycle read latency) between several LED output channels (icnd2110-style serialisers) and one frame-loader write port.
- Serves each channel's level read_request/read_address with a read_data word plus a one-cycle read_finished_strobe, which writes that word into the channel's prefetch fifo.
- Pending loader writes take priority over reads. Reads are granted round-robin.

---
 rtl/spram_read_arbiter.sv | 143 ++++++++++++++
 tb/tb_spram_read_arbiter.sv | 237 +++++++++++++++++++++++
 2 files changed

// File: rtl/spram_read_arbiter.sv
// Shares one single-port 16-bit SPRAM between CHANNELS read channels and one loader write port.
// Held loader writes win over reads; reads are granted round-robin, one per three cycles.
module spram_read_arbiter #(
  parameter int CHANNELS = 4,
  parameter int ADDR_W   = 14
) (
  input  logic                         clk_i,
  input  logic                         rst_i,
  input  logic [CHANNELS*ADDR_W-1:0]   read_address_i,
  input  logic [CHANNELS-1:0]          read_request_i,
  output logic [15:0]                  read_data_o,
  output logic [CHANNELS-1:0]          read_finished_strobe_o,
  input  logic [ADDR_W-1:0]            write_address_i,
  input  logic [15:0]                  write_data_i,
  input  logic                         write_strobe_i,
  output logic                         write_busy_o,
  output logic                         write_overflow_o,
  output logic [ADDR_W-1:0]            mem_address_o,
  output logic [15:0]                  mem_data_in_o,
  output logic                         mem_write_enable_o,
  input  logic [15:0]                  mem_data_out_i
);

  // state    | meaning
  // IDLE     | arbitrate: held write first, else round-robin read grant
  // WRITE    | SPRAM commits the held write; holding register drains
  // READ     | SPRAM samples the granted read address
  // CAPTURE  | SPRAM output valid; latch it and strobe the granted channel
  typedef enum logic [1:0] {ST_IDLE, ST_WRITE, ST_READ, ST_CAPTURE} state_t;

  localparam int CH_W = (CHANNELS > 1) ? $clog2(CHANNELS) : 1;

  state_t                state_q;
  logic [CH_W-1:0]       rr_ptr_q;
  logic [CHANNELS-1:0]   strobe_q;
  logic [15:0]           read_data_q;
  logic [ADDR_W-1:0]     mem_address_q;
  logic [15:0]           mem_data_in_q;
  logic                  mem_we_q;
  logic                  hold_valid_q;
  logic [ADDR_W-1:0]     hold_addr_q;
  logic [15:0]           hold_data_q;
  logic                  overflow_q;

  logic [CHANNELS-1:0]   eligible_d;
  logic                  grant_vld_d;
  logic [CH_W-1:0]       grant_d;
  logic [ADDR_W-1:0]     rd_addr_d;
  logic [CHANNELS-1:0]   strobe_d;

  // A channel strobed this cycle is masked: its fifo full flag has not caught up yet.
  always_comb begin
    int idx;
    idx         = 0;
    eligible_d  = read_request_i & ~strobe_q;
    grant_vld_d = 1'b0;
    grant_d     = '0;
    for (int i = 1; i <= CHANNELS; i++) begin
      idx = int'(rr_ptr_q) + i;
      if (idx >= CHANNELS) idx = idx - CHANNELS;
      if (!grant_vld_d && eligible_d[CH_W'(idx)]) begin
        grant_vld_d = 1'b1;
        grant_d     = CH_W'(idx);
      end
    end
  end

  always_comb begin
    rd_addr_d = '0;
    strobe_d  = '0;
    for (int c = 0; c < CHANNELS; c++) begin
      if (grant_d == CH_W'(c)) rd_addr_d = read_address_i[c*ADDR_W +: ADDR_W];
      strobe_d[c] = (rr_ptr_q == CH_W'(c));
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q       <= ST_IDLE;
      rr_ptr_q      <= CH_W'(CHANNELS - 1);
      strobe_q      <= '0;
      read_data_q   <= '0;
      mem_address_q <= '0;
      mem_data_in_q <= '0;
      mem_we_q      <= 1'b0;
      hold_valid_q  <= 1'b0;
      hold_addr_q   <= '0;
      hold_data_q   <= '0;
      overflow_q    <= 1'b0;
    end else begin
      strobe_q <= '0;

      // A strobe landing in the drain cycle refills the holding register.
      if (write_strobe_i) begin
        if (!hold_valid_q || state_q == ST_WRITE) begin
          hold_valid_q <= 1'b1;
          hold_addr_q  <= write_address_i;
          hold_data_q  <= write_data_i;
        end else begin
          overflow_q <= 1'b1;
        end
      end

      case (state_q)
        ST_IDLE: begin
          if (hold_valid_q) begin
            mem_address_q <= hold_addr_q;
            mem_data_in_q <= hold_data_q;
            mem_we_q      <= 1'b1;
            state_q       <= ST_WRITE;
          end else if (grant_vld_d) begin
            mem_address_q <= rd_addr_d;
            rr_ptr_q      <= grant_d;
            state_q       <= ST_READ;
          end
        end
        ST_WRITE: begin
          mem_we_q <= 1'b0;
          if (!write_strobe_i) hold_valid_q <= 1'b0;
          state_q <= ST_IDLE;
        end
        ST_READ: begin
          state_q <= ST_CAPTURE;
        end
        ST_CAPTURE: begin
          read_data_q <= mem_data_out_i;
          strobe_q    <= strobe_d;
          state_q     <= ST_IDLE;
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  assign read_data_o            = read_data_q;
  assign read_finished_strobe_o = strobe_q;
  assign write_busy_o           = hold_valid_q;
  assign write_overflow_o       = overflow_q;
  assign mem_address_o          = mem_address_q;
  assign mem_data_in_o          = mem_data_in_q;
  assign mem_write_enable_o     = mem_we_q;

endmodule

// File: tb/tb_spram_read_arbiter.sv
// Directed bench for spram_read_arbiter with a behavioural 1-cycle-latency SPRAM model.
// Inputs are driven and outputs sampled on the falling edge.
module tb_spram_read_arbiter;
  localparam int CH = 4;
  localparam int AW = 14;

  logic              clk = 1'b0;
  logic              rst = 1'b1;
  logic [CH*AW-1:0]  rd_addr = '0;
  logic [CH-1:0]     rd_req = '0;
  logic [15:0]       rd_data;
  logic [CH-1:0]     rd_strobe;
  logic [AW-1:0]     wr_addr = '0;
  logic [15:0]       wr_data = '0;
  logic              wr_strobe = 1'b0;
  logic              wr_busy;
  logic              wr_ovf;
  logic [AW-1:0]     mem_addr;
  logic [15:0]       mem_din;
  logic              mem_we;
  logic [15:0]       mem_dout = '0;

  logic [15:0]       mem [0:(1<<AW)-1];

  int n_tests = 0;
  int n_fail  = 0;

  spram_read_arbiter #(.CHANNELS(CH), .ADDR_W(AW)) dut (
    .clk_i                  (clk),
    .rst_i                  (rst),
    .read_address_i         (rd_addr),
    .read_request_i         (rd_req),
    .read_data_o            (rd_data),
    .read_finished_strobe_o (rd_strobe),
    .write_address_i        (wr_addr),
    .write_data_i           (wr_data),
    .write_strobe_i         (wr_strobe),
    .write_busy_o           (wr_busy),
    .write_overflow_o       (wr_ovf),
    .mem_address_o          (mem_addr),
    .mem_data_in_o          (mem_din),
    .mem_write_enable_o     (mem_we),
    .mem_data_out_i         (mem_dout)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (mem_we) mem[mem_addr] <= mem_din;
    mem_dout <= mem[mem_addr];
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(negedge clk);
  endtask

  task automatic do_reset();
    rst = 1'b1;
    tick();
    tick();
    rst = 1'b0;
  endtask

  logic [15:0] exp_rr [4];
  logic [3:0]  exp_s;
  logic [3:0]  seen;

  initial begin
    for (int a = 0; a < (1<<AW); a++) mem[a] = 16'h0000;
    mem[5]  = 16'hA5C3;
    mem[10] = 16'hB001;
    mem[20] = 16'hC002;
    mem[30] = 16'hD003;
    exp_rr[0] = 16'hA5C3;
    exp_rr[1] = 16'hB001;
    exp_rr[2] = 16'hC002;
    exp_rr[3] = 16'hD003;
    rd_addr[0*AW +: AW] = 14'd5;
    rd_addr[1*AW +: AW] = 14'd10;
    rd_addr[2*AW +: AW] = 14'd20;
    rd_addr[3*AW +: AW] = 14'd30;

    // reset values and single read latency
    do_reset();
    chk("rst_strobe", rd_strobe, 0);
    chk("rst_rdata", rd_data, 0);
    chk("rst_maddr", mem_addr, 0);
    chk("rst_mdin", mem_din, 0);
    chk("rst_mwe", mem_we, 0);
    chk("rst_busy", wr_busy, 0);
    chk("rst_ovf", wr_ovf, 0);
    rd_req = 4'b0001;
    tick();
    chk("t1_maddr", mem_addr, 5);
    chk("t1_strobe_k1", rd_strobe, 0);
    tick();
    chk("t1_strobe_k2", rd_strobe, 0);
    tick();
    chk("t1_strobe_k3", rd_strobe, 4'b0001);
    chk("t1_rdata", rd_data, 16'hA5C3);
    rd_req = 4'b0000;
    tick();
    chk("t1_strobe_k4", rd_strobe, 0);
    chk("t1_rdata_hold", rd_data, 16'hA5C3);

    // all channels requesting: 0,1,2,3,0 every 3 cycles
    do_reset();
    rd_req = 4'b1111;
    for (int k = 1; k <= 15; k++) begin
      tick();
      exp_s = (k % 3 == 0) ? 4'(1 << ((k/3 - 1) % 4)) : 4'b0000;
      chk("rr_strobe", rd_strobe, exp_s);
      if (k % 3 == 0) chk("rr_data", rd_data, exp_rr[(k/3 - 1) % 4]);
    end
    rd_req = 4'b0000;
    tick();
    tick();

    // channel 1 request lags the strobe by one cycle: no second read
    do_reset();
    rd_req = 4'b0010;
    tick();
    tick();
    tick();
    chk("c1_strobe", rd_strobe, 4'b0010);
    chk("c1_rdata", rd_data, 16'hB001);
    tick();
    chk("c1_no_dbl_k4", rd_strobe, 0);
    rd_req = 4'b0000;
    seen = '0;
    for (int k = 5; k <= 10; k++) begin
      tick();
      seen = seen | rd_strobe;
    end
    chk("c1_no_dbl_later", seen, 0);

    // write arrives while channel 2 is in READ
    do_reset();
    rd_req = 4'b0100;
    tick();
    chk("w_busy_k1", wr_busy, 0);
    wr_addr = 14'd7;
    wr_data = 16'h1234;
    wr_strobe = 1'b1;
    tick();
    wr_strobe = 1'b0;
    chk("w_busy_k2", wr_busy, 1);
    chk("w_mwe_k2", mem_we, 0);
    tick();
    chk("w_rd_first", rd_strobe, 4'b0100);
    chk("w_rd_data", rd_data, 16'hC002);
    chk("w_mwe_k3", mem_we, 0);
    rd_req = 4'b0000;
    tick();
    chk("w_mwe_k4", mem_we, 1);
    chk("w_maddr_k4", mem_addr, 7);
    chk("w_mdin_k4", mem_din, 16'h1234);
    tick();
    chk("w_mwe_k5", mem_we, 0);
    chk("w_busy_k5", wr_busy, 0);
    chk("w_mem7", mem[7], 16'h1234);
    rd_addr[3*AW +: AW] = 14'd7;
    rd_req = 4'b1000;
    tick();
    tick();
    tick();
    chk("w_readback_strobe", rd_strobe, 4'b1000);
    chk("w_readback_data", rd_data, 16'h1234);
    rd_req = 4'b0000;
    rd_addr[3*AW +: AW] = 14'd30;

    // two back-to-back writes during a read: second dropped
    do_reset();
    rd_req = 4'b0001;
    tick();
    wr_addr = 14'd40;
    wr_data = 16'h4444;
    wr_strobe = 1'b1;
    tick();
    chk("ov_busy_k2", wr_busy, 1);
    chk("ov_flag_k2", wr_ovf, 0);
    wr_addr = 14'd41;
    wr_data = 16'h5555;
    tick();
    wr_strobe = 1'b0;
    chk("ov_flag_k3", wr_ovf, 1);
    chk("ov_strobe", rd_strobe, 4'b0001);
    chk("ov_rdata", rd_data, 16'hA5C3);
    rd_req = 4'b0000;
    tick();
    chk("ov_mwe_k4", mem_we, 1);
    chk("ov_maddr_k4", mem_addr, 40);
    chk("ov_mdin_k4", mem_din, 16'h4444);
    tick();
    chk("ov_busy_k5", wr_busy, 0);
    tick();
    chk("ov_mem40", mem[40], 16'h4444);
    chk("ov_mem41", mem[41], 16'h0000);
    chk("ov_sticky", wr_ovf, 1);

    // reset during CAPTURE abandons the read; channel 0 searched first afterwards
    rd_req = 4'b0010;
    tick();
    tick();
    rst = 1'b1;
    tick();
    chk("rc_strobe", rd_strobe, 0);
    chk("rc_rdata", rd_data, 0);
    chk("rc_maddr", mem_addr, 0);
    chk("rc_mdin", mem_din, 0);
    chk("rc_mwe", mem_we, 0);
    chk("rc_busy", wr_busy, 0);
    chk("rc_ovf", wr_ovf, 0);
    rst = 1'b0;
    rd_req = 4'b0011;
    tick();
    chk("rc_grant_addr", mem_addr, 5);
    tick();
    tick();
    chk("rc_grant_strobe", rd_strobe, 4'b0001);
    chk("rc_grant_data", rd_data, 16'hA5C3);
    rd_req = 4'b0000;
    tick();
    tick();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
